// File: rtl/btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debouncer
//  Description : Push-button conditioner. A two-flop synchronizer feeds a
//                four-state debounce FSM with a stability counter. The block
//                produces a clean level, a single-cycle rise pulse and a
//                single-cycle long-press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int LONG_CYCLES     = 100_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn,
    output logic btn_rise,
    output logic btn_long
);

    localparam int c_cnt_w  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_hold_w = $clog2(LONG_CYCLES + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_zero  = '0;
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(LONG_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(LONG_CYCLES - 1);

    localparam logic [1:0] c_st_low  = 2'd0;
    localparam logic [1:0] c_st_l2h  = 2'd1;
    localparam logic [1:0] c_st_high = 2'd2;
    localparam logic [1:0] c_st_h2l  = 2'd3;

    logic                r_sync1;
    logic                r_sync2;
    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_hold_w-1:0] r_hold;
    logic                r_btn;
    logic                r_rise;
    logic                r_long;

    logic [1:0]          w_state_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic                w_btn_nxt;
    logic                w_rise_nxt;
    logic                w_long_nxt;

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce next-state and stability-counter logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_low: begin
                if (r_sync2) begin
                    w_state_nxt = c_st_l2h;
                    w_cnt_nxt   = c_cnt_one;
                end else begin
                    w_cnt_nxt   = c_cnt_zero;
                end
            end
            c_st_l2h: begin
                if (!r_sync2) begin
                    w_state_nxt = c_st_low;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_high;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            c_st_high: begin
                if (!r_sync2) begin
                    w_state_nxt = c_st_h2l;
                    w_cnt_nxt   = c_cnt_one;
                end
            end
            c_st_h2l: begin
                if (r_sync2) begin
                    w_state_nxt = c_st_high;
                    w_cnt_nxt   = c_cnt_zero;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_low;
                    w_cnt_nxt   = c_cnt_zero;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = c_st_low;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    // Output and hold-counter next values, derived from the next state so
    // the registered outputs line up with the state they describe.
    always_comb begin
        w_btn_nxt  = (w_state_nxt == c_st_high) || (w_state_nxt == c_st_h2l);
        w_rise_nxt = (r_state == c_st_l2h) && (w_state_nxt == c_st_high);
        w_hold_nxt = r_hold;
        w_long_nxt = 1'b0;
        if (w_state_nxt == c_st_low) begin
            // A completed release clears the press; no long pulse on this edge.
            w_hold_nxt = '0;
        end else if (r_btn && (r_hold != c_hold_max)) begin
            w_hold_nxt = r_hold + c_hold_one;
            w_long_nxt = (r_hold == c_hold_last);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_low;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_btn   <= 1'b0;
            r_rise  <= 1'b0;
            r_long  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_btn   <= w_btn_nxt;
            r_rise  <= w_rise_nxt;
            r_long  <= w_long_nxt;
        end
    end

    assign btn      = r_btn;
    assign btn_rise = r_rise;
    assign btn_long = r_long;

endmodule
`default_nettype wire

// File: tb/tb_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btn_debouncer
//  Description : Directed self-checking bench for btn_debouncer with
//                DEBOUNCE_CYCLES=4 and LONG_CYCLES=20. Every clock edge is
//                followed by a check of btn / btn_rise / btn_long against
//                hand-derived values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_debouncer;

    logic clock;
    logic reset;
    logic btn_raw;
    logic btn;
    logic btn_rise;
    logic btn_long;

    int    n_chk;
    int    n_fail;
    int    edge_no;
    string phase;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_raw),
        .btn     (btn),
        .btn_rise(btn_rise),
        .btn_long(btn_long)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string sig, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s edge %0d: observed %b expected %b",
                   phase, sig, edge_no, obs, exp);
        end
    endtask

    // Advance one rising edge, settle, then check all three outputs.
    task automatic cyc(input logic eb, input logic er, input logic el);
        @(posedge clock);
        #1;
        edge_no++;
        chk("btn",      btn,      eb);
        chk("btn_rise", btn_rise, er);
        chk("btn_long", btn_long, el);
    endtask

    task automatic run(input int n, input logic eb, input logic er, input logic el);
        for (int i = 0; i < n; i++) cyc(eb, er, el);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        edge_no = 0;
        reset   = 1'b1;
        btn_raw = 1'b1;

        // 1: reset held two cycles with the button pressed, then released
        phase = "reset";
        run(2, 0, 0, 0);
        reset = 1'b0;
        run(5, 0, 0, 0);          // E0 .. E0+4
        cyc(1, 1, 0);             // E0+5
        cyc(1, 0, 0);             // E0+6
        btn_raw = 1'b0;
        run(5, 1, 0, 0);          // E1 .. E1+4
        cyc(0, 0, 0);             // E1+5
        run(3, 0, 0, 0);

        // 2: clean press, raw high for 10 captures
        phase = "clean";
        btn_raw = 1'b1;
        run(5, 0, 0, 0);          // E0 .. E0+4
        cyc(1, 1, 0);             // E0+5
        run(4, 1, 0, 0);          // E0+6 .. E0+9
        btn_raw = 1'b0;
        run(5, 1, 0, 0);          // E0+10 .. E0+14
        cyc(0, 0, 0);             // E0+15
        run(3, 0, 0, 0);

        // 3: press bounce 1,0,1,0,1 then stable high
        phase = "bounce";
        btn_raw = 1'b1; cyc(0, 0, 0);   // A
        btn_raw = 1'b0; cyc(0, 0, 0);   // A+1
        btn_raw = 1'b1; cyc(0, 0, 0);   // A+2
        btn_raw = 1'b0; cyc(0, 0, 0);   // A+3
        btn_raw = 1'b1; cyc(0, 0, 0);   // A+4, last 0->1 capture
        run(4, 0, 0, 0);                // A+5 .. A+8
        cyc(1, 1, 0);                   // A+9 = rise edge R
        run(2, 1, 0, 0);                // A+10, A+11

        // 4: release bounce of 3 cycles; hold keeps counting from R
        phase = "relbounce";
        btn_raw = 1'b0;
        run(3, 1, 0, 0);                // A+12 .. A+14
        btn_raw = 1'b1;
        run(14, 1, 0, 0);               // A+15 .. A+28
        cyc(1, 0, 1);                   // A+29 = R+20
        cyc(1, 0, 0);                   // A+30
        btn_raw = 1'b0;
        run(5, 1, 0, 0);                // E1 .. E1+4
        cyc(0, 0, 0);                   // E1+5
        run(3, 0, 0, 0);

        // 5a: long press held 30 cycles
        phase = "long";
        btn_raw = 1'b1;
        run(5, 0, 0, 0);          // E0 .. E0+4
        cyc(1, 1, 0);             // E0+5 = R
        run(19, 1, 0, 0);         // R+1 .. R+19
        cyc(1, 0, 1);             // R+20
        run(4, 1, 0, 0);          // E0+26 .. E0+29
        btn_raw = 1'b0;
        run(5, 1, 0, 0);          // E1 .. E1+4
        cyc(0, 0, 0);
        run(3, 0, 0, 0);

        // 5b: press giving 15 cycles of btn=1, too short for a long pulse
        phase = "short";
        btn_raw = 1'b1;
        run(5, 0, 0, 0);
        cyc(1, 1, 0);             // E0+5
        run(9, 1, 0, 0);          // E0+6 .. E0+14
        btn_raw = 1'b0;
        run(5, 1, 0, 0);          // E0+15 .. E0+19
        cyc(0, 0, 0);
        run(10, 0, 0, 0);

        // 6a: reset while in L2H, raw kept high through reset
        phase = "rst_l2h";
        btn_raw = 1'b1;
        run(3, 0, 0, 0);          // FSM now in L2H
        reset = 1'b1;
        run(2, 0, 0, 0);
        reset = 1'b0;
        run(5, 0, 0, 0);          // new E0 .. E0+4
        cyc(1, 1, 0);             // R
        run(10, 1, 0, 0);         // R+1 .. R+10, hold = 10

        // 6b: reset with hold = 10; pending long pulse must never appear
        phase = "rst_hold";
        reset = 1'b1;
        cyc(0, 0, 0);
        btn_raw = 1'b0;
        cyc(0, 0, 0);
        reset = 1'b0;
        run(30, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_debouncer.md
# btn_debouncer

Conditions a raw, bouncing, asynchronous push-button input into a clean level plus single-cycle event pulses. It sits directly upstream of the light timer: `btn` drives the timer's `btn` input, and `btn_rise` / `btn_long` serve same-clock consumers. The block has a 2-FF synchronizer, a 4-state debounce FSM with a stability counter, and a long-press hold counter.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz). Legal range ≥ 2.
- `LONG_CYCLES`, default 100_000_000: cycles `btn` must stay high, counted from its rising edge, before `btn_long` fires (2 s at 50 MHz). Legal range ≥ 1.

Ports:
- `clock` input 1: system clock, rising-edge.
- `reset` input 1: synchronous, active-high.
- `btn_raw` input 1: raw button, asynchronous, bouncing.
- `btn` output 1: debounced level.
- `btn_rise` output 1: one-cycle pulse when `btn` goes 0→1.
- `btn_long` output 1: one-cycle pulse when a press reaches `LONG_CYCLES`.

## Operation

- **Synchronizer:** `btn_raw` → `sync1` → `sync2` (`s`). Both flops reset to 0. Only `s` feeds the FSM.
- **FSM states:** `LOW`, `L2H`, `HIGH`, `H2L`. Reset state is `LOW`.
- **Debounce counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES+1)`. Reset value 0.
  - `LOW`: if `s`=1, go to `L2H` with `cnt`=1. Otherwise hold, `cnt`=0.
  - `L2H`: if `s`=0, go to `LOW` with `cnt`=0 (bounce rejected). Else if `cnt`=`DEBOUNCE_CYCLES`−1, go to `HIGH` and `cnt`=0. Else `cnt`++.
  - `HIGH`: if `s`=0, go to `H2L` with `cnt`=1.
  - `H2L`: if `s`=1, go to `HIGH` with `cnt`=0 (bounce rejected; press continues). Else if `cnt`=`DEBOUNCE_CYCLES`−1, go to `LOW`. Else `cnt`++.
- **Outputs:**
  - `btn` is registered, =1 exactly in states `HIGH` and `H2L`.
  - `btn_rise` is registered, =1 for the single cycle after the `L2H`→`HIGH` edge.
- **Hold counter:** `hold`, width `$clog2(LONG_CYCLES+1)`.
  - Counts +1 every cycle while `btn`=1, including in `H2L`.
  - Saturates at `LONG_CYCLES`.
  - Cleared to 0 on entry to `LOW` and on reset.
  - `btn_long` pulses for one cycle on the edge at which `hold` reaches `LONG_CYCLES`. It fires at most once per press.
- **Arithmetic:** all counters are unsigned. Neither counter ever wraps.

## Timing

- **Reset values:** all outputs 0, `sync1`/`sync2`/`cnt`/`hold` = 0, state `LOW`.
- **Rise latency:** let edge E0 be the first edge at which `btn_raw`=1 is captured into `sync1`. With `btn_raw` stable, `btn` and `btn_rise` are 1 after edge E0+`DEBOUNCE_CYCLES`+1.
- **Fall latency:** the same rule applies to the falling edge. `btn` is 0 after edge E1+`DEBOUNCE_CYCLES`+1.
- **Glitch rejection:** any `s` glitch shorter than `DEBOUNCE_CYCLES` samples causes no change on `btn`, and no `btn_rise` or `btn_long`.
- **Long press:** `btn_long` is 1 after edge (`btn` rise edge)+`LONG_CYCLES`.
  - A release bounce in `H2L` that returns to `HIGH` does not restart `hold`.
  - If the release completes before `hold` reaches `LONG_CYCLES`, there is no `btn_long`.
- **`btn_rise` / `btn_long` coincidence:** the two pulses never coincide, because `LONG_CYCLES` ≥ 1.
- **Reset mid-operation:** reset dominates every transition.
  - If `btn_raw` stays high through reset, the press is treated as new. E0 is the first edge with `reset`=0, and `btn_rise` follows the normal rise latency.
  - A `btn_long` pending at reset never fires.

## Test plan

Tests use overrides `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.

1. **Reset values:** hold `reset`=1 for 2 cycles with `btn_raw`=1 → `btn`, `btn_rise`, `btn_long` are 0 throughout. `btn`=1 after the 5th edge following the first edge with `reset`=0.
2. **Clean press:** `btn_raw` 0→1, captured at edge 10, held for 10 cycles → `btn`=1 and `btn_rise`=1 after edge 15. `btn_rise`=0 after edge 16. No `btn_long`.
3. **Bounce rejection:** `btn_raw` toggles 1,0,1,0,1 with one cycle each, then stays 1 → one `btn_rise` only, 5 edges after the last 0→1 capture. `btn` never glitches.
4. **Release bounce:** while `btn`=1, `btn_raw` drops for 3 cycles, then returns to 1 → `btn` stays 1 and `hold` is not cleared. A final stable release drops `btn` 5 edges after capture.
5. **Long press:** press held 30 cycles → `btn_long` is a single pulse exactly 20 edges after the `btn_rise` edge. No second pulse. A press lasting 15 cycles of `btn`=1 → no `btn_long`.
6. **Reset mid-press:** assert `reset` while in `L2H` and again while `hold`=10 → outputs are 0 the next cycle. No stale `btn_rise` or `btn_long` after release.
